// File: rtl/cuckoo_insert_ctrl.sv
// Two-table cuckoo-hash insertion sequencer.
// Probes table 1 and then table 2 alternately. Each occupied, non-matching
// slot is overwritten with the carried entry, and the displaced victim is
// relocated to its slot in the other table. The chain stops after MAX_KICKS
// evictions.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a request, req_ready high
// S_READ  | read strobe for slot (tsel, addr); data arrives next cycle
// S_CHECK | classify returned slot: place / duplicate / fail / evict
// S_RESP  | one-cycle done pulse with status
module cuckoo_insert_ctrl #(
    parameter int KEY_W     = 32,
    parameter int IDX_W     = 5,
    parameter int MAX_KICKS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [KEY_W-1:0]           req_key,
    input  logic [IDX_W-1:0]           req_idx1,
    input  logic [IDX_W-1:0]           req_idx2,
    output logic                       mem_sel,
    output logic [IDX_W-1:0]           mem_addr,
    output logic                       mem_rd_en,
    input  logic [KEY_W+2*IDX_W:0]     mem_rdata,
    output logic                       mem_we,
    output logic [KEY_W+2*IDX_W:0]     mem_wdata,
    output logic                       done,
    output logic [1:0]                 status,
    output logic [7:0]                 kicks,
    output logic [KEY_W-1:0]           fail_key,
    output logic [IDX_W-1:0]           fail_idx1,
    output logic [IDX_W-1:0]           fail_idx2
);

    localparam int ENT_W = 1 + KEY_W + 2*IDX_W;
    // Kick limits above 255 can never be reached by the saturating counter.
    localparam logic [7:0] MAX_K8 = 8'(MAX_KICKS);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_CHECK, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [IDX_W-1:0]  i1_q, i1_d;
    logic [IDX_W-1:0]  i2_q, i2_d;
    logic              tsel_q, tsel_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic [7:0]        kicks_q, kicks_d;
    logic [1:0]        status_q, status_d;
    logic [KEY_W-1:0]  fkey_q, fkey_d;
    logic [IDX_W-1:0]  fi1_q, fi1_d;
    logic [IDX_W-1:0]  fi2_q, fi2_d;
    logic              we_c, rd_c;

    logic              rd_valid;
    logic [KEY_W-1:0]  rd_key;
    logic [IDX_W-1:0]  rd_i1, rd_i2;

    assign rd_valid = mem_rdata[ENT_W-1];
    assign rd_key   = mem_rdata[ENT_W-2 -: KEY_W];
    assign rd_i1    = mem_rdata[2*IDX_W-1 -: IDX_W];
    assign rd_i2    = mem_rdata[IDX_W-1:0];

    // Strobes are gated by reset so an abort never lands a write on its reset edge.
    assign mem_we    = we_c & ~rst;
    assign mem_rd_en = rd_c & ~rst;
    assign mem_sel   = tsel_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = {1'b1, key_q, i1_q, i2_q};
    assign kicks     = kicks_q;
    assign status    = status_q;
    assign fail_key  = fkey_q;
    assign fail_idx1 = fi1_q;
    assign fail_idx2 = fi2_q;

    // Next-state and strobe decode.
    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        i1_d      = i1_q;
        i2_d      = i2_q;
        tsel_d    = tsel_q;
        addr_d    = addr_q;
        kicks_d   = kicks_q;
        status_d  = status_q;
        fkey_d    = fkey_q;
        fi1_d     = fi1_q;
        fi2_d     = fi2_q;
        req_ready = 1'b0;
        done      = 1'b0;
        rd_c      = 1'b0;
        we_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    key_d   = req_key;
                    i1_d    = req_idx1;
                    i2_d    = req_idx2;
                    tsel_d  = 1'b0;
                    addr_d  = req_idx1;
                    kicks_d = 8'd0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_c    = 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!rd_valid) begin
                    we_c     = 1'b1;
                    status_d = 2'd0;
                    state_d  = S_RESP;
                end else if (rd_key == key_q) begin
                    status_d = 2'd1;
                    state_d  = S_RESP;
                end else if (kicks_q == MAX_K8) begin
                    status_d = 2'd2;
                    fkey_d   = key_q;
                    fi1_d    = i1_q;
                    fi2_d    = i2_q;
                    state_d  = S_RESP;
                end else begin
                    // Place the carried entry here and carry the victim to its other table.
                    we_c    = 1'b1;
                    key_d   = rd_key;
                    i1_d    = rd_i1;
                    i2_d    = rd_i2;
                    tsel_d  = ~tsel_q;
                    addr_d  = tsel_q ? rd_i1 : rd_i2;
                    kicks_d = (kicks_q == 8'hFF) ? kicks_q : kicks_q + 8'd1;
                    state_d = S_READ;
                end
            end
            S_RESP: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            key_q    <= '0;
            i1_q     <= '0;
            i2_q     <= '0;
            tsel_q   <= 1'b0;
            addr_q   <= '0;
            kicks_q  <= 8'd0;
            status_q <= 2'd0;
            fkey_q   <= '0;
            fi1_q    <= '0;
            fi2_q    <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            tsel_q   <= tsel_d;
            addr_q   <= addr_d;
            kicks_q  <= kicks_d;
            status_q <= status_d;
            fkey_q   <= fkey_d;
            fi1_q    <= fi1_d;
            fi2_q    <= fi2_d;
        end
    end

endmodule

// File: tb/tb_cuckoo_insert_ctrl.sv
// Bench for cuckoo_insert_ctrl: bench-side table memories, a reference
// insertion model operating on plain arrays, directed vectors and random inserts.
module tb_cuckoo_insert_ctrl;

    localparam int KEY_W = 32;
    localparam int IDX_W = 5;
    localparam int MK    = 2;
    localparam int ENT_W = 1 + KEY_W + 2*IDX_W;
    localparam int NS    = 1 << IDX_W;

    typedef logic [ENT_W-1:0]       ent_t;
    typedef logic [ENT_W+IDX_W:0]   wr_t;

    logic              clk, rst;
    logic              req_valid, req_ready;
    logic [KEY_W-1:0]  req_key;
    logic [IDX_W-1:0]  req_idx1, req_idx2;
    logic              mem_sel, mem_rd_en, mem_we;
    logic [IDX_W-1:0]  mem_addr;
    ent_t              mem_rdata, mem_wdata;
    logic              done;
    logic [1:0]        status;
    logic [7:0]        kicks;
    logic [KEY_W-1:0]  fail_key;
    logic [IDX_W-1:0]  fail_idx1, fail_idx2;

    cuckoo_insert_ctrl #(.KEY_W(KEY_W), .IDX_W(IDX_W), .MAX_KICKS(MK)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_idx1(req_idx1), .req_idx2(req_idx2),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .done(done), .status(status), .kicks(kicks),
        .fail_key(fail_key), .fail_idx1(fail_idx1), .fail_idx2(fail_idx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read table memories with a write trace.
    ent_t mem [2][NS];
    logic clr;
    wr_t  wq[$];
    int   both_cnt;
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NS; i++) begin
                mem[0][i] <= '0;
                mem[1][i] <= '0;
            end
            both_cnt <= 0;
        end else begin
            if (mem_rd_en) mem_rdata <= mem[mem_sel][mem_addr];
            if (mem_we) begin
                mem[mem_sel][mem_addr] <= mem_wdata;
                wq.push_back({mem_sel, mem_addr, mem_wdata});
            end
            if (mem_we && mem_rd_en) both_cnt <= both_cnt + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: the cuckoo insertion algorithm on plain arrays.
    ent_t mt [2][NS];
    wr_t  mq[$];

    task automatic model_insert(input logic [KEY_W-1:0] k, input logic [IDX_W-1:0] a1, a2,
                                output logic [1:0] st, output int nk,
                                output logic [KEY_W-1:0] fk, output logic [IDX_W-1:0] f1, f2);
        logic [KEY_W-1:0] ck;
        logic [IDX_W-1:0] c1, c2, a;
        int t;
        bit fin;
        ent_t slot;
        ck = k; c1 = a1; c2 = a2; t = 0; a = a1; nk = 0; st = 2'd0;
        fk = '0; f1 = '0; f2 = '0; fin = 1'b0;
        mq.delete();
        while (!fin) begin
            slot = mt[t][a];
            if (!slot[ENT_W-1]) begin
                mt[t][a] = {1'b1, ck, c1, c2};
                mq.push_back({t[0], a, 1'b1, ck, c1, c2});
                st = 2'd0; fin = 1'b1;
            end else if (slot[ENT_W-2 -: KEY_W] == ck) begin
                st = 2'd1; fin = 1'b1;
            end else if (nk == MK) begin
                st = 2'd2; fk = ck; f1 = c1; f2 = c2; fin = 1'b1;
            end else begin
                mt[t][a] = {1'b1, ck, c1, c2};
                mq.push_back({t[0], a, 1'b1, ck, c1, c2});
                ck = slot[ENT_W-2 -: KEY_W];
                c1 = slot[2*IDX_W-1 -: IDX_W];
                c2 = slot[IDX_W-1:0];
                t  = 1 - t;
                a  = (t == 1) ? c2 : c1;
                nk++;
            end
        end
    endtask

    // One insert through the DUT, compared against the model.
    task automatic run_op(input string tag, input logic [KEY_W-1:0] k, input logic [IDX_W-1:0] a1, a2,
                          output logic [1:0] st_o, output int nk_o, output int lat_o,
                          output logic [KEY_W-1:0] fk_o);
        logic [1:0] mst;
        int mnk, w, lat;
        logic [KEY_W-1:0] mfk;
        logic [IDX_W-1:0] mf1, mf2;
        model_insert(k, a1, a2, mst, mnk, mfk, mf1, mf2);
        wq.delete();
        req_valid = 1'b1; req_key = k; req_idx1 = a1; req_idx2 = a2;
        w = 0;
        while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
        chk({tag, "_ready"}, 64'(req_ready), 64'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
        chk({tag, "_done"}, 64'(done), 64'(1));
        chk({tag, "_lat"}, 64'(lat), 64'(3 + 2*mnk));
        chk({tag, "_status"}, 64'(status), 64'(mst));
        chk({tag, "_kicks"}, 64'(kicks), 64'(mnk));
        if (mst == 2'd2) begin
            chk({tag, "_fkey"}, 64'(fail_key), 64'(mfk));
            chk({tag, "_fi1"}, 64'(fail_idx1), 64'(mf1));
            chk({tag, "_fi2"}, 64'(fail_idx2), 64'(mf2));
        end
        st_o = status; nk_o = int'(kicks); lat_o = lat; fk_o = fail_key;
        @(posedge clk); #1;
        chk({tag, "_hold"}, 64'({status, kicks}), 64'({mst, 8'(mnk)}));
        chk({tag, "_nwr"}, 64'(wq.size()), 64'(mq.size()));
        for (int i = 0; i < wq.size() && i < mq.size(); i++)
            chk({tag, "_wr"}, 64'(wq[i]), 64'(mq[i]));
    endtask

    typedef struct {
        logic [KEY_W-1:0] key;
        logic [IDX_W-1:0] i1, i2;
        logic [1:0]       st;
        int               nk;
        int               lat;
        logic [KEY_W-1:0] fk;
    } vec_t;

    vec_t vt[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] st;
        int nk, lat, acc, dn, viol, w, nw;
        bit pending;
        logic [KEY_W-1:0] fk, rk;
        logic [IDX_W-1:0] r1, r2;

        vt[0] = '{32'hA5, 5'd3, 5'd7,  2'd0, 0, 3, 32'h0};
        vt[1] = '{32'hA5, 5'd3, 5'd7,  2'd1, 0, 3, 32'h0};
        vt[2] = '{32'h11, 5'd4, 5'd9,  2'd0, 0, 3, 32'h0};
        vt[3] = '{32'h22, 5'd4, 5'd10, 2'd0, 1, 5, 32'h0};
        vt[4] = '{32'h1,  5'd5, 5'd5,  2'd0, 0, 3, 32'h0};
        vt[5] = '{32'h2,  5'd5, 5'd5,  2'd0, 1, 5, 32'h0};
        vt[6] = '{32'h3,  5'd5, 5'd5,  2'd2, 2, 7, 32'h1};
        vt[7] = '{32'h4,  5'd5, 5'd5,  2'd2, 2, 7, 32'h2};

        rst = 1'b1; clr = 1'b1; req_valid = 1'b0;
        req_key = '0; req_idx1 = '0; req_idx2 = '0;
        for (int i = 0; i < NS; i++) begin mt[0][i] = '0; mt[1][i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; clr = 1'b0;

        chk("rst_ready", 64'(req_ready), 64'(1));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_rd", 64'(mem_rd_en), 64'(0));
        chk("rst_we", 64'(mem_we), 64'(0));
        chk("rst_kicks", 64'(kicks), 64'(0));
        chk("rst_status", 64'(status), 64'(0));
        chk("rst_fail", 64'({fail_key, fail_idx1, fail_idx2}), 64'(0));

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].key, vt[i].i1, vt[i].i2, st, nk, lat, fk);
            chk($sformatf("vec%0d_st_tbl", i), 64'(st), 64'(vt[i].st));
            chk($sformatf("vec%0d_nk_tbl", i), 64'(nk), 64'(vt[i].nk));
            chk($sformatf("vec%0d_lat_tbl", i), 64'(lat), 64'(vt[i].lat));
            if (vt[i].st == 2'd2)
                chk($sformatf("vec%0d_fk_tbl", i), 64'(fk), 64'(vt[i].fk));
        end
        chk("t1s3", 64'(mem[0][3]), 64'({1'b1, 32'hA5, 5'd3, 5'd7}));
        chk("t1s4", 64'(mem[0][4]), 64'({1'b1, 32'h22, 5'd4, 5'd10}));
        chk("t2s9", 64'(mem[1][9]), 64'({1'b1, 32'h11, 5'd4, 5'd9}));
        chk("t1s5", 64'(mem[0][5]), 64'({1'b1, 32'h4, 5'd5, 5'd5}));
        chk("t2s5", 64'(mem[1][5]), 64'({1'b1, 32'h3, 5'd5, 5'd5}));

        // req_valid held high: each duplicate op is IDLE + 3 busy cycles.
        wq.delete();
        req_valid = 1'b1; req_key = 32'hA5; req_idx1 = 5'd3; req_idx2 = 5'd7;
        acc = 0; dn = 0; viol = 0; pending = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin dn++; pending = 1'b0; end
            if (pending && req_ready) viol++;
            if (req_ready && req_valid) begin
                if (pending) viol++;
                acc++; pending = 1'b1;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        chk("hold_accepts", 64'(acc), 64'(10));
        chk("hold_dones", 64'(dn), 64'(10));
        chk("hold_busy_ready", 64'(viol), 64'(0));
        chk("hold_writes", 64'(wq.size()), 64'(0));
        @(posedge clk); #1;

        // Reset in the CHECK cycle that follows the first eviction.
        wq.delete();
        req_valid = 1'b1; req_key = 32'h33; req_idx1 = 5'd3; req_idx2 = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        while (!mem_we && w < 20) begin @(posedge clk); #1; w++; end
        chk("mr_we_seen", 64'(mem_we), 64'(1));
        @(posedge clk); #1;
        chk("mr_reread", 64'(mem_rd_en), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mr_we_gated", 64'(mem_we), 64'(0));
        nw = wq.size();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_writes", 64'(nw), 64'(1));
        chk("mr_writes_after", 64'(wq.size()), 64'(1));
        chk("mr_ready", 64'(req_ready), 64'(1));
        chk("mr_strobes", 64'({mem_rd_en, mem_we}), 64'(0));
        chk("mr_done", 64'(done), 64'(0));
        chk("mr_kicks", 64'(kicks), 64'(0));
        chk("mr_t1s3", 64'(mem[0][3]), 64'({1'b1, 32'h33, 5'd3, 5'd7}));
        for (int i = 0; i < NS; i++) begin mt[0][i] = mem[0][i]; mt[1][i] = mem[1][i]; end
        run_op("post_rst", 32'h44, 5'd20, 5'd21, st, nk, lat, fk);
        chk("post_rst_st", 64'(st), 64'(0));

        // Random inserts from a small key pool so duplicates, chains and failures all occur.
        for (int n = 0; n < 60; n++) begin
            rk = KEY_W'($urandom_range(1, 40));
            r1 = IDX_W'(rk % 8);
            r2 = IDX_W'((rk * 5 + 3) % 16);
            run_op($sformatf("rnd%0d", n), rk, r1, r2, st, nk, lat, fk);
        end

        for (int t = 0; t < 2; t++)
            for (int i = 0; i < NS; i++)
                chk($sformatf("tbl%0d_%0d", t, i), 64'(mem[t][i]), 64'(mt[t][i]));
        chk("no_dual_strobe", 64'(both_cnt), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
